// File: rtl/seed_pkg.sv
// Shared SEED transmit-path types and widths.
// Used by the byte serializer and its phase timer.
package seed_pkg;

    localparam int SEED_BLK_W = 128;
    localparam int BYTE_W     = 8;
    localparam int TMR_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } tx_state_t;

endpackage

// File: rtl/seed_tx_phase_timer.sv
// Loadable down-counter; expired is high once the count reaches zero.
// A load takes priority over counting; en=0 freezes the count.
module seed_tx_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/seed_256_to_byte_tx.sv
// Serializes one captured SEED block to the host MSB byte first, one registered cycle after each decision.
// out_en stalls acceptance and the SETUP phase only; a block arriving mid-transfer is dropped and flagged.
module seed_256_to_byte_tx
    import seed_pkg::*;
#(
    parameter int unsigned NBYTES     = SEED_BLK_W / BYTE_W,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 1,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       out_en,
    input  logic                       blk_valid,
    input  logic [BYTE_W*NBYTES-1:0]   blk_in,
    output logic [BYTE_W-1:0]          part_SEED,
    output logic                       load_rpi3,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    localparam int BLK_W = BYTE_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES + 1);
    localparam logic [TMR_W-1:0] SETUP_V  = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] STROBE_V = TMR_W'(STROBE_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_V   = TMR_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    tx_state_t        state, state_nxt;
    logic [BLK_W-1:0] shift, shift_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             ovr_nxt;
    logic             tmr_load, tmr_en, tmr_exp;
    logic [TMR_W-1:0] tmr_val;

    // Only SETUP waits on the host; STROBE and HOLD always run to completion.
    assign tmr_en = (state == SETUP) ? out_en : 1'b1;

    seed_tx_phase_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_exp)
    );

    always_comb begin
        state_nxt = state;
        shift_nxt = shift;
        idx_nxt   = idx;
        ovr_nxt   = overrun;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE, DONE: begin
                if (blk_valid && out_en) begin
                    shift_nxt = blk_in;
                    idx_nxt   = '0;
                    state_nxt = SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = SETUP_V;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SETUP: begin
                ovr_nxt = overrun | blk_valid;
                if (out_en && tmr_exp) begin
                    state_nxt = STROBE;
                    tmr_load  = 1'b1;
                    tmr_val   = STROBE_V;
                end
            end
            STROBE: begin
                ovr_nxt = overrun | blk_valid;
                if (tmr_exp) begin
                    state_nxt = HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = HOLD_V;
                end
            end
            HOLD: begin
                ovr_nxt = overrun | blk_valid;
                if (tmr_exp) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        shift_nxt = shift << BYTE_W;
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = SETUP;
                        tmr_load  = 1'b1;
                        tmr_val   = SETUP_V;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it without a combinational path.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            shift     <= '0;
            idx       <= '0;
            overrun   <= 1'b0;
            part_SEED <= '0;
            load_rpi3 <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            idx       <= idx_nxt;
            overrun   <= ovr_nxt;
            part_SEED <= (state_nxt == IDLE) ? '0 : shift_nxt[BLK_W-1 -: BYTE_W];
            load_rpi3 <= (state_nxt == STROBE);
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);
        end
    end

endmodule

// File: doc/seed_256_to_byte_tx.md
Name: seed_256_to_byte_tx

Overview:
Output serializer for the SEED core: the byte-serial transmitter mirroring the input byte assembler. Captures one 128-bit SEED result block on a one-cycle valid pulse and presents it to the RPi3 host as 16 bytes on part_SEED, MSB byte first. Each byte is qualified by a load_rpi3 strobe with the same setup/strobe/hold cadence the host uses on the input side. Sits between the SEED round datapath output and the top-level pins part_SEED/load_rpi3/done.

Parameters:
NBYTES, 16, bytes per block; block width = 8*NBYTES.
SETUP_CYC, 1, cycles part_SEED is stable before load_rpi3 rises (>=1).
STROBE_CYC, 1, cycles load_rpi3 is high per byte (>=1).
HOLD_CYC, 1, cycles part_SEED is held after load_rpi3 falls (>=1).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-low reset.
out_en  in  1  host ready / transmit enable; gates acceptance and the SETUP phase.
blk_valid  in  1  one-cycle pulse: blk_in holds a finished SEED block.
blk_in  in  8*NBYTES  result block; [8*NBYTES-1 -: 8] is byte 0.
part_SEED  out  8  current output byte.
load_rpi3  out  1  byte strobe to host.
busy  out  1  high from capture until return to IDLE.
done  out  1  one-cycle pulse after the last byte's HOLD.
overrun  out  1  sticky: blk_valid arrived while busy (not in DONE).

Behaviour:
- Reset (reset==0 at edge): state IDLE, part_SEED=0x00, load_rpi3=0, busy=0, done=0, overrun=0, byte counter=0, shift register=0. Reset applies mid-transfer; the transfer is abandoned with no further strobes.
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: part_SEED=0x00. If blk_valid&&out_en: capture blk_in into the shift register, counter=0, go to SETUP. If blk_valid&&!out_en: block dropped, overrun unchanged.
- SETUP: part_SEED=shift[top byte], load_rpi3=0. Phase timer counts SETUP_CYC cycles only while out_en=1; out_en=0 stalls here indefinitely with outputs held. At expiry, go to STROBE.
- STROBE: load_rpi3=1 for exactly STROBE_CYC cycles. Not affected by out_en. Then go to HOLD.
- HOLD: load_rpi3=0 and the byte is held for HOLD_CYC cycles. If counter==NBYTES-1, go to DONE. Otherwise shift left 8 bits, counter+1, go to SETUP.
- DONE: one cycle; done=1, part_SEED=last byte. If blk_valid&&out_en in this cycle, capture and go to SETUP (back-to-back, no IDLE cycle). Otherwise go to IDLE.
- busy=1 in SETUP/STROBE/HOLD/DONE. blk_valid in SETUP/STROBE/HOLD: ignored, overrun<=1 (sticky until reset).
- Timing at defaults: capture at edge 0; byte k on part_SEED after edge 3k; load_rpi3 high after edge 3k+1 for one cycle. DONE follows edge 48, IDLE follows edge 49. Per-byte period = SETUP_CYC+STROBE_CYC+HOLD_CYC.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package seed_pkg: SEED_BLK_W=128, BYTE_W=8, tx state enum {IDLE,SETUP,STROBE,HOLD,DONE}.
- One sub-module: seed_tx_phase_timer, a loadable down-counter with enable and expiry flag, reused for the SETUP, STROBE and HOLD phases.

Test Plan:
- Reset, then blk_valid with blk_in=EE54D13EBCAE706D226BC3142CD40D4A, out_en=1 -> 16 strobes; bytes sampled at load_rpi3 are EE,54,D1,...,0D,4A. done pulses once at cycle 49; busy low from cycle 50.
- Same block with out_en dropped for 5 cycles during byte 3 SETUP -> load_rpi3 stays low for those cycles. Byte sequence is unchanged; done is delayed by exactly 5 cycles.
- blk_valid pulsed again during byte 7 STROBE -> overrun=1 and stays 1. The transfer completes with the original data.
- blk_valid coincident with the DONE cycle -> the next block's byte 0 appears on part_SEED the following cycle with no IDLE gap, and done pulses again after 49 more cycles.
- reset=0 asserted during byte 9 HOLD -> next cycle all outputs are 0. No further load_rpi3; a new block after reset transmits correctly from byte 0.
- Parameters SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=1 -> per-byte period of 6 cycles, load_rpi3 high for 3 cycles, done after edge 96.
